// File: rtl/pipelined_control_unit.sv
// Control unit for the 5-stage RV32I core: decodes the ID opcode into a
// control bundle, carries it with per-stage valid bits through EX, the
// MEM_LAT memory stages and WB, applies stall/flush, and owns the ECALL halt FSM.
module pipelined_control_unit #(
    parameter int ALU_OP_W      = 2,
    parameter int MEM_LAT       = 1,
    parameter int ECALL_HALT_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          id_opcode,
    input  logic                id_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic                x17_is_10,
    output logic                ex_alu_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_is_branch,
    output logic                ex_is_jal,
    output logic                ex_is_jalr,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic                wb_pc_to_reg,
    output logic                wb_valid,
    output logic                illegal_op,
    output logic                is_halted
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // WB group bit positions: {reg_write, mem_to_reg, pc_to_reg, ecall}
    localparam int WB_RW  = 3;
    localparam int WB_M2R = 2;
    localparam int WB_P2R = 1;
    localparam int WB_EC  = 0;

    // decoded bundle (ID)
    logic                dec_legal_p0;
    logic                dec_src_p0;
    logic [ALU_OP_W-1:0] dec_alu_op_p0;
    logic                dec_br_p0;
    logic                dec_jal_p0;
    logic                dec_jalr_p0;
    logic                dec_mr_p0;
    logic                dec_mw_p0;
    logic [3:0]          dec_wb_p0;

    // EX stage
    logic                vld_p1;
    logic                src_p1;
    logic [ALU_OP_W-1:0] alu_op_p1;
    logic                br_p1;
    logic                jal_p1;
    logic                jalr_p1;
    logic                mr_p1;
    logic                mw_p1;
    logic [3:0]          wb_p1;

    // MEM stages M1..M<MEM_LAT>; load/store strobes only matter in M1
    logic [MEM_LAT-1:0]       vld_p2;
    logic [MEM_LAT-1:0][3:0]  wb_p2;
    logic                     mr_p2;
    logic                     mw_p2;

    // WB stage
    logic       vld_p3;
    logic [3:0] wb_p3;

    logic [0:0] state_q;
    logic       illegal_q;
    logic       id_take;
    logic       load_ex;
    logic       halt_now;

    // Opcode decode of the instruction sitting in ID
    always_comb begin
        dec_legal_p0  = 1'b1;
        dec_src_p0    = 1'b0;
        dec_alu_op_p0 = '0;
        dec_br_p0     = 1'b0;
        dec_jal_p0    = 1'b0;
        dec_jalr_p0   = 1'b0;
        dec_mr_p0     = 1'b0;
        dec_mw_p0     = 1'b0;
        dec_wb_p0     = 4'b0000;
        case (id_opcode)
            OP_LOAD: begin
                dec_src_p0        = 1'b1;
                dec_mr_p0         = 1'b1;
                dec_wb_p0[WB_RW]  = 1'b1;
                dec_wb_p0[WB_M2R] = 1'b1;
            end
            OP_STORE: begin
                dec_src_p0 = 1'b1;
                dec_mw_p0  = 1'b1;
            end
            OP_BRANCH: begin
                dec_br_p0     = 1'b1;
                dec_alu_op_p0 = ALU_OP_W'(2'd3);
            end
            OP_R: begin
                dec_alu_op_p0    = ALU_OP_W'(2'd1);
                dec_wb_p0[WB_RW] = 1'b1;
            end
            OP_I: begin
                dec_src_p0       = 1'b1;
                dec_alu_op_p0    = ALU_OP_W'(2'd2);
                dec_wb_p0[WB_RW] = 1'b1;
            end
            OP_JAL: begin
                dec_src_p0        = 1'b1;
                dec_jal_p0        = 1'b1;
                dec_wb_p0[WB_RW]  = 1'b1;
                dec_wb_p0[WB_P2R] = 1'b1;
            end
            OP_JALR: begin
                dec_src_p0        = 1'b1;
                dec_jalr_p0       = 1'b1;
                dec_wb_p0[WB_RW]  = 1'b1;
                dec_wb_p0[WB_P2R] = 1'b1;
            end
            OP_ECALL: begin
                dec_wb_p0[WB_EC] = 1'b1;
            end
            default: dec_legal_p0 = 1'b0;
        endcase
    end

    // ID accepts only when not stalled, not flushed and the core is running
    assign id_take  = id_valid & ~stall & ~flush & (state_q == ST_RUN);
    assign load_ex  = id_take & dec_legal_p0;
    assign halt_now = (state_q == ST_RUN) & vld_p3 & wb_p3[WB_EC] & x17_is_10
                      & (ECALL_HALT_EN != 0);

    // Pipeline advance, flush kill, halt FSM and registered illegal pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            illegal_q <= 1'b0;
            vld_p1    <= 1'b0;
            src_p1    <= 1'b0;
            alu_op_p1 <= '0;
            br_p1     <= 1'b0;
            jal_p1    <= 1'b0;
            jalr_p1   <= 1'b0;
            mr_p1     <= 1'b0;
            mw_p1     <= 1'b0;
            wb_p1     <= 4'b0000;
            vld_p2    <= '0;
            wb_p2     <= '0;
            mr_p2     <= 1'b0;
            mw_p2     <= 1'b0;
            vld_p3    <= 1'b0;
            wb_p3     <= 4'b0000;
        end else if (halt_now) begin
            // halting drains nothing: every in-flight instruction is dropped
            state_q   <= ST_HALTED;
            illegal_q <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= '0;
            vld_p3    <= 1'b0;
        end else begin
            illegal_q <= id_take & ~dec_legal_p0;

            // ID -> EX
            vld_p1    <= load_ex;
            src_p1    <= load_ex & dec_src_p0;
            alu_op_p1 <= load_ex ? dec_alu_op_p0 : '0;
            br_p1     <= load_ex & dec_br_p0;
            jal_p1    <= load_ex & dec_jal_p0;
            jalr_p1   <= load_ex & dec_jalr_p0;
            mr_p1     <= load_ex & dec_mr_p0;
            mw_p1     <= load_ex & dec_mw_p0;
            wb_p1     <= load_ex ? dec_wb_p0 : 4'b0000;

            // EX -> M1 (flush kills the instruction leaving EX)
            vld_p2[0] <= vld_p1 & ~flush;
            wb_p2[0]  <= wb_p1;
            mr_p2     <= mr_p1;
            mw_p2     <= mw_p1;

            // M(i-1) -> M(i)
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_p2[i] <= vld_p2[i-1];
                wb_p2[i]  <= wb_p2[i-1];
            end

            // M<MEM_LAT> -> WB
            vld_p3 <= vld_p2[MEM_LAT-1];
            wb_p3  <= wb_p2[MEM_LAT-1];
        end
    end

    assign ex_alu_src    = vld_p1 & src_p1;
    assign ex_alu_op     = alu_op_p1 & {ALU_OP_W{vld_p1}};
    assign ex_is_branch  = vld_p1 & br_p1;
    assign ex_is_jal     = vld_p1 & jal_p1;
    assign ex_is_jalr    = vld_p1 & jalr_p1;
    assign mem_read      = vld_p2[0] & mr_p2;
    assign mem_write     = vld_p2[0] & mw_p2;
    assign wb_reg_write  = vld_p3 & wb_p3[WB_RW];
    assign wb_mem_to_reg = vld_p3 & wb_p3[WB_M2R];
    assign wb_pc_to_reg  = vld_p3 & wb_p3[WB_P2R];
    assign wb_valid      = vld_p3;
    assign illegal_op    = illegal_q;
    assign is_halted     = (state_q == ST_HALTED);

endmodule
